// File: rtl/mac_pkg.sv
// Shared definitions for the posit MAC fraction-multiplier scheduler.
// Holds the default operand width and requester count, a clog2 helper that
// never yields a zero-width tag, and the default requester tag type.
package mac_pkg;

   localparam int N_DEFAULT       = 5;
   localparam int NUM_REQ_DEFAULT = 4;

   // A single requester bit still needs a 1-bit tag, so clamp small counts.
   function automatic int clog2_safe(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef logic [clog2_safe(NUM_REQ_DEFAULT)-1:0] req_tag_t;

endpackage

// File: rtl/mult_rr_scheduler_if.sv
// Request/result bus of the shared fraction multiplier.
//   req_valid/req_x/req_y : per-requester requests (requester i at [i*N +: N])
//   req_ready             : one-hot grant/accept back to the requesters
//   res_valid/res_ready   : result handshake
//   res_r/res_id          : 2N-bit product and the tag of its requester
// master = requesters + result consumer, slave = the scheduler.
interface mult_rr_scheduler_if #(
   parameter int N       = mac_pkg::N_DEFAULT,
   parameter int NUM_REQ = mac_pkg::NUM_REQ_DEFAULT
);
   localparam int ID_W = mac_pkg::clog2_safe(NUM_REQ);

   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*N-1:0] req_x;
   logic [NUM_REQ*N-1:0] req_y;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 res_valid;
   logic                 res_ready;
   logic [2*N-1:0]       res_r;
   logic [ID_W-1:0]      res_id;

   modport master (
      output req_valid, req_x, req_y, res_ready,
      input  req_ready, res_valid, res_r, res_id
   );

   modport slave (
      input  req_valid, req_x, req_y, res_ready,
      output req_ready, res_valid, res_r, res_id
   );

endinterface

// File: rtl/mult_rr_scheduler_mult.sv
// Full-width unsigned N x N multiplier, purely combinational.
//   X, Y : N-bit operands
//   R    : 2N-bit product, never truncated
module IntMultiplier_F0_uid12 #(
   parameter int N = 5
) (
   input  logic [N-1:0]   X,
   input  logic [N-1:0]   Y,
   output logic [2*N-1:0] R
);

   assign R = (2*N)'(X) * (2*N)'(Y);

endmodule

// File: rtl/mult_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : index where the search starts (wraps modulo NUM_REQ)
//   en      : grant enable; gnt_idx/any are valid regardless of en
//   grant   : one-hot grant, all-zero when !en or no request
//   gnt_idx : index of the first requester at or after ptr
//   any     : at least one request present
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    gnt_idx,
   output logic               any
);

   always_comb begin
      int idx;
      grant   = '0;
      gnt_idx = '0;
      any     = 1'b0;
      idx     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (!any && req[idx]) begin
            any     = 1'b1;
            gnt_idx = ID_W'(idx);
         end
      end
      if (any && en) grant[gnt_idx] = 1'b1;
   end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one N x N multiplier among NUM_REQ requesters.
// Two registered stages: S1 captures the granted operands and tag, the
// multiplier works on S1, S2 is the output register. One product per cycle,
// accept-to-result latency 2 cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of both valid bits (beats the stall)
//   bus        : request/result interface (slave side)
//   busy       : a stage holds valid data
module mult_rr_scheduler
   import mac_pkg::*;
#(
   parameter int N       = N_DEFAULT,
   parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   mult_rr_scheduler_if.slave bus,
   output logic              busy
);

   localparam int ID_W = clog2_safe(NUM_REQ);

   typedef struct packed {
      logic [N-1:0]    x;
      logic [N-1:0]    y;
      logic [ID_W-1:0] id;
   } s1_t;

   s1_t             s1_q, s1_d;
   logic            s1_valid_q, s1_valid_d;
   logic [2*N-1:0]  res_r_q, res_r_d;
   logic [ID_W-1:0] res_id_q, res_id_d;
   logic            res_valid_q, res_valid_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

   logic               en;
   logic               arb_en;
   logic               any;
   logic               accept;
   logic [ID_W-1:0]    gnt_idx;
   logic [NUM_REQ-1:0] grant;
   logic [2*N-1:0]     prod;

   // Whole pipeline moves only when the output register can be overwritten.
   assign en     = !res_valid_q || bus.res_ready;
   assign arb_en = en && !flush;
   assign accept = any && arb_en;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req     (bus.req_valid),
      .ptr     (rr_ptr_q),
      .en      (arb_en),
      .grant   (grant),
      .gnt_idx (gnt_idx),
      .any     (any)
   );

   IntMultiplier_F0_uid12 #(
      .N (N)
   ) u_mult (
      .X (s1_q.x),
      .Y (s1_q.y),
      .R (prod)
   );

   always_comb begin
      s1_d        = s1_q;
      s1_valid_d  = s1_valid_q;
      res_r_d     = res_r_q;
      res_id_d    = res_id_q;
      res_valid_d = res_valid_q;
      rr_ptr_d    = rr_ptr_q;
      if (flush) begin
         // Data registers keep their contents; only validity is dropped.
         s1_valid_d  = 1'b0;
         res_valid_d = 1'b0;
      end else if (en) begin
         res_r_d     = prod;
         res_id_d    = s1_q.id;
         res_valid_d = s1_valid_q;
         if (accept) begin
            s1_d.x     = bus.req_x[int'(gnt_idx)*N +: N];
            s1_d.y     = bus.req_y[int'(gnt_idx)*N +: N];
            s1_d.id    = gnt_idx;
            s1_valid_d = 1'b1;
            rr_ptr_d   = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
         end else begin
            s1_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q        <= '0;
         s1_valid_q  <= 1'b0;
         res_r_q     <= '0;
         res_id_q    <= '0;
         res_valid_q <= 1'b0;
         rr_ptr_q    <= '0;
      end else begin
         s1_q        <= s1_d;
         s1_valid_q  <= s1_valid_d;
         res_r_q     <= res_r_d;
         res_id_q    <= res_id_d;
         res_valid_q <= res_valid_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   // Grants must vanish immediately while reset is held, not at the next edge.
   assign bus.req_ready = grant & {NUM_REQ{rst_n}};
   assign bus.res_valid = res_valid_q;
   assign bus.res_r     = res_r_q;
   assign bus.res_id    = res_id_q;
   assign busy          = s1_valid_q || res_valid_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed bench for mult_rr_scheduler (N=5, NUM_REQ=4).
module tb_mult_rr_scheduler;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic busy;
   int   checks = 0;
   int   failures = 0;

   mult_rr_scheduler_if #(.N(5), .NUM_REQ(4)) bus ();

   mult_rr_scheduler #(.N(5), .NUM_REQ(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input int x, input int y);
      bus.req_x[i*5 +: 5] = 5'(x);
      bus.req_y[i*5 +: 5] = 5'(y);
   endtask

   task automatic do_reset();
      bus.req_valid = 4'b0000;
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      #2 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      bus.req_valid = 4'b1111;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready got=%b exp=0000", bus.req_ready); end
      checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%b exp=0", bus.res_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (bus.res_r !== 10'd0) begin failures++; $display("FAIL rst_res_r got=%0d exp=0", bus.res_r); end
      checks++; if (bus.res_id !== 2'd0) begin failures++; $display("FAIL rst_res_id got=%0d exp=0", bus.res_id); end
      bus.req_valid = 4'b0000;
      #2 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      set_op(0, 3, 7);
      bus.req_valid = 4'b0001;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", bus.req_ready); end
      tick();
      bus.req_valid = 4'b0000;
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_s1 got valid=%b busy=%b exp valid=0 busy=1", bus.res_valid, busy); end
      tick();
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b1 || bus.res_r !== 10'd21 || bus.res_id !== 2'd0) begin failures++; $display("FAIL single_result got v=%b r=%0d id=%0d exp v=1 r=21 id=0", bus.res_valid, bus.res_r, bus.res_id); end
      tick();
      @(negedge clk);
      checks++; if (busy !== 1'b0 || bus.res_valid !== 1'b0) begin failures++; $display("FAIL single_idle got busy=%b v=%b exp 0 0", busy, bus.res_valid); end
      tick();
   endtask

   task automatic test_round_robin();
      logic [3:0] eg;
      int         k;
      do_reset();
      for (int i = 0; i < 4; i++) set_op(i, i + 1, 31);
      bus.req_valid = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         eg = 4'(1 << (c % 4));
         checks++; if (bus.req_ready !== eg) begin failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, bus.req_ready, eg); end
         if (c < 2) begin
            checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL rr_fill c=%0d got v=%b exp=0", c, bus.res_valid); end
         end else begin
            k = (c - 2) % 4;
            checks++; if (bus.res_valid !== 1'b1 || bus.res_r !== 10'((k + 1) * 31) || bus.res_id !== 2'(k)) begin failures++; $display("FAIL rr_result c=%0d got v=%b r=%0d id=%0d exp v=1 r=%0d id=%0d", c, bus.res_valid, bus.res_r, bus.res_id, (k + 1) * 31, k); end
         end
         tick();
      end
      bus.req_valid = 4'b0000;
      @(negedge clk);
      checks++; if (bus.res_r !== 10'd93 || bus.res_id !== 2'd2) begin failures++; $display("FAIL rr_drain0 got r=%0d id=%0d exp r=93 id=2", bus.res_r, bus.res_id); end
      tick();
      @(negedge clk);
      checks++; if (bus.res_r !== 10'd124 || bus.res_id !== 2'd3) begin failures++; $display("FAIL rr_drain1 got r=%0d id=%0d exp r=124 id=3", bus.res_r, bus.res_id); end
      tick();
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle got busy=%b exp=0", busy); end
      tick();
   endtask

   task automatic test_max_operands();
      set_op(0, 31, 31);
      bus.req_valid = 4'b0001;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL max_ready got=%b exp=0001", bus.req_ready); end
      tick();
      bus.req_valid = 4'b0000;
      tick();
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b1 || bus.res_r !== 10'b1111000001 || bus.res_id !== 2'd0) begin failures++; $display("FAIL max_result got v=%b r=%0d id=%0d exp v=1 r=961 id=0", bus.res_valid, bus.res_r, bus.res_id); end
      tick();
      // Pointer is now 1; requester 1 idle, so requester 2 wins. Zero operand.
      set_op(2, 0, 31);
      bus.req_valid = 4'b0100;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL zero_ready got=%b exp=0100", bus.req_ready); end
      tick();
      bus.req_valid = 4'b0000;
      tick();
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b1 || bus.res_r !== 10'd0 || bus.res_id !== 2'd2) begin failures++; $display("FAIL zero_result got v=%b r=%0d id=%0d exp v=1 r=0 id=2", bus.res_valid, bus.res_r, bus.res_id); end
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      set_op(0, 2, 3);
      set_op(1, 4, 5);
      bus.req_valid = 4'b0011;
      bus.res_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL bp_ready0 got=%b exp=0001", bus.req_ready); end
      tick();
      bus.req_valid = 4'b0010;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL bp_ready1 got=%b exp=0010", bus.req_ready); end
      tick();
      set_op(2, 7, 1);
      set_op(3, 6, 6);
      set_op(0, 1, 1);
      bus.req_valid = 4'b1101;
      bus.res_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (bus.res_valid !== 1'b1 || bus.res_r !== 10'd6 || bus.res_id !== 2'd0 || busy !== 1'b1) begin failures++; $display("FAIL bp_hold c=%0d got v=%b r=%0d id=%0d busy=%b exp v=1 r=6 id=0 busy=1", c, bus.res_valid, bus.res_r, bus.res_id, busy); end
         checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL bp_hold_ready c=%0d got=%b exp=0000", c, bus.req_ready); end
         tick();
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0100 || bus.res_r !== 10'd6) begin failures++; $display("FAIL bp_resume got ready=%b r=%0d exp ready=0100 r=6", bus.req_ready, bus.res_r); end
      tick();
      bus.req_valid = 4'b1001;
      @(negedge clk);
      checks++; if (bus.res_r !== 10'd20 || bus.res_id !== 2'd1 || bus.req_ready !== 4'b1000) begin failures++; $display("FAIL bp_second got r=%0d id=%0d ready=%b exp r=20 id=1 ready=1000", bus.res_r, bus.res_id, bus.req_ready); end
      tick();
      bus.req_valid = 4'b0001;
      @(negedge clk);
      checks++; if (bus.res_r !== 10'd7 || bus.res_id !== 2'd2 || bus.req_ready !== 4'b0001) begin failures++; $display("FAIL bp_third got r=%0d id=%0d ready=%b exp r=7 id=2 ready=0001", bus.res_r, bus.res_id, bus.req_ready); end
      tick();
      bus.req_valid = 4'b0000;
      @(negedge clk);
      checks++; if (bus.res_r !== 10'd36 || bus.res_id !== 2'd3) begin failures++; $display("FAIL bp_fourth got r=%0d id=%0d exp r=36 id=3", bus.res_r, bus.res_id); end
      tick();
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b1 || bus.res_r !== 10'd1 || bus.res_id !== 2'd0) begin failures++; $display("FAIL bp_fifth got v=%b r=%0d id=%0d exp v=1 r=1 id=0", bus.res_valid, bus.res_r, bus.res_id); end
      tick();
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle got busy=%b exp=0", busy); end
      tick();
   endtask

   task automatic test_flush();
      // Pointer is 1 here.
      set_op(1, 3, 3);
      set_op(2, 5, 5);
      bus.req_valid = 4'b0110;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL fl_ready1 got=%b exp=0010", bus.req_ready); end
      tick();
      bus.req_valid = 4'b0100;
      tick();
      flush = 1'b1;
      set_op(0, 1, 1);
      set_op(3, 2, 2);
      bus.req_valid = 4'b1001;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL fl_no_grant got=%b exp=0000", bus.req_ready); end
      tick();
      flush = 1'b0;
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL fl_cleared got v=%b busy=%b exp 0 0", bus.res_valid, busy); end
      checks++; if (bus.res_r !== 10'd9 || bus.res_id !== 2'd1) begin failures++; $display("FAIL fl_keep_data got r=%0d id=%0d exp r=9 id=1", bus.res_r, bus.res_id); end
      checks++; if (bus.req_ready !== 4'b1000) begin failures++; $display("FAIL fl_ptr got=%b exp=1000", bus.req_ready); end
      tick();
      bus.req_valid = 4'b0000;
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL fl_no_stale got v=%b exp=0", bus.res_valid); end
      tick();
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b1 || bus.res_r !== 10'd4 || bus.res_id !== 2'd3) begin failures++; $display("FAIL fl_after got v=%b r=%0d id=%0d exp v=1 r=4 id=3", bus.res_valid, bus.res_r, bus.res_id); end
      tick();
   endtask

   task automatic test_async_reset();
      // Pointer is 0 here.
      set_op(0, 1, 2);
      set_op(1, 3, 4);
      bus.req_valid = 4'b0011;
      tick();
      bus.req_valid = 4'b0010;
      tick();
      set_op(0, 2, 9);
      bus.req_valid = 4'b1111;
      #2;
      checks++; if (bus.res_valid !== 1'b1 || bus.res_r !== 10'd2) begin failures++; $display("FAIL ar_pre got v=%b r=%0d exp v=1 r=2", bus.res_valid, bus.res_r); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.res_valid !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 4'b0000) begin failures++; $display("FAIL ar_drop got v=%b busy=%b ready=%b exp 0 0 0000", bus.res_valid, busy, bus.req_ready); end
      checks++; if (bus.res_r !== 10'd0) begin failures++; $display("FAIL ar_res_r got=%0d exp=0", bus.res_r); end
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 4'b0001 || bus.res_valid !== 1'b0) begin failures++; $display("FAIL ar_first got ready=%b v=%b exp ready=0001 v=0", bus.req_ready, bus.res_valid); end
      tick();
      bus.req_valid = 4'b0000;
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL ar_no_stale got v=%b busy=%b exp v=0 busy=1", bus.res_valid, busy); end
      tick();
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b1 || bus.res_r !== 10'd18 || bus.res_id !== 2'd0) begin failures++; $display("FAIL ar_result got v=%b r=%0d id=%0d exp v=1 r=18 id=0", bus.res_valid, bus.res_r, bus.res_id); end
      tick();
   endtask

   initial begin
      bus.req_valid = 4'b0000;
      bus.req_x     = '0;
      bus.req_y     = '0;
      bus.res_ready = 1'b1;
      test_reset();
      test_single();
      test_round_robin();
      test_max_operands();
      test_backpressure();
      test_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout reached without completing the test sequence");
      $fatal(1);
   end

endmodule
